booth_seq_multiplier: RTL and testbench

Parametrised, multi-cycle radix-4 Booth multiplier for the multdiv unit. It retires one Booth digit per clock into a shifting accumulator. It supports signed and unsigned operands of any even WIDTH. It uses a start/ready/valid handshake so the pipeline can stall on it, and it replaces the fixed 32x16, counter-indexed partial-product selector.

---
 rtl/booth_seq_multiplier_pkg.sv | 34 +++
 rtl/booth_pp_select.sv | 31 +++
 rtl/booth_seq_multiplier.sv | 137 +++++++++++++
 tb/tb_booth_seq_multiplier.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_seq_multiplier_pkg.sv
// Shared multdiv definitions: radix-4 Booth digit codes, sequencer states
// and the triplet-to-digit decoder used by every Booth partial-product path.
package booth_seq_multiplier_pkg;

  localparam int TRIPLET_W = 3;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_POS1 = 3'd1,
    BOOTH_POS2 = 3'd2,
    BOOTH_NEG1 = 3'd3,
    BOOTH_NEG2 = 3'd4
  } booth_digit_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit 0 of the triplet is the previous digit's top bit (or the implicit 0).
  function automatic booth_digit_e booth_decode(input logic [TRIPLET_W-1:0] triplet);
    booth_digit_e digit;
    case (triplet)
      3'b001, 3'b010: digit = BOOTH_POS1;
      3'b011:         digit = BOOTH_POS2;
      3'b100:         digit = BOOTH_NEG2;
      3'b101, 3'b110: digit = BOOTH_NEG1;
      default:        digit = BOOTH_ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/booth_pp_select.sv
// Combinational radix-4 Booth partial-product selector: one multiplier
// triplet and a (WIDTH+2)-bit extended multiplicand give pp in {0,+-M,+-2M}.
module booth_pp_select
  import booth_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [TRIPLET_W-1:0] triplet,
  input  logic [WIDTH+1:0]     multiplicand,
  output logic [WIDTH+1:0]     pp
);

  booth_digit_e     digit;
  logic [WIDTH+1:0] mcand_x2;

  // The two guard bits of the extended multiplicand make 2M fit without loss.
  assign mcand_x2 = {multiplicand[WIDTH:0], 1'b0};

  always_comb begin
    digit = booth_decode(triplet);
    pp    = '0;
    case (digit)
      BOOTH_POS1: pp = multiplicand;
      BOOTH_POS2: pp = mcand_x2;
      BOOTH_NEG1: pp = -multiplicand;
      BOOTH_NEG2: pp = -mcand_x2;
      default:    pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Multi-cycle radix-4 Booth multiplier: one digit per clock into a shifting
// accumulator, start/ready/valid handshake, signed or unsigned operands.
module booth_seq_multiplier
  import booth_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = WIDTH / 2 + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 result_valid,
  output logic [2*WIDTH-1:0]   product,
  output logic                 overflow
);

  localparam int MW = WIDTH + 3;
  localparam int AW = 2 * WIDTH + 4;
  localparam int CW = $clog2(STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  state_e             state_reg, state_next;
  logic [CW-1:0]      count_reg, count_next;
  logic [AW-1:0]      acc_reg, acc_next;
  logic [MW-1:0]      mplier_reg, mplier_next;
  logic [WIDTH+1:0]   mcand_reg, mcand_next;
  logic               signed_reg, signed_next;
  logic [2*WIDTH-1:0] product_reg, product_next;
  logic               overflow_reg, overflow_next;

  logic [WIDTH+1:0]   pp;
  logic [WIDTH+1:0]   acc_hi_sum;
  logic [AW-1:0]      acc_step;
  logic [2*WIDTH-1:0] final_product;
  logic [WIDTH:0]     signed_top;
  logic               final_overflow;
  logic               accept;
  logic               ext_a;
  logic               ext_b;

  booth_pp_select #(
    .WIDTH(WIDTH)
  ) u_pp_select (
    .triplet      (mplier_reg[2:0]),
    .multiplicand (mcand_reg),
    .pp           (pp)
  );

  // Partial products land in the top WIDTH+2 bits; after STEPS shifts of two
  // the accumulator holds the exact product in its low 2*WIDTH bits.
  assign acc_hi_sum = acc_reg[AW-1:WIDTH+2] + pp;
  assign acc_step   = $signed({acc_hi_sum, acc_reg[WIDTH+1:0]}) >>> 2;

  assign final_product  = acc_step[2*WIDTH-1:0];
  assign signed_top     = final_product[2*WIDTH-1:WIDTH-1];
  assign final_overflow = signed_reg ? !((&signed_top) || !(|signed_top))
                                     : (|final_product[2*WIDTH-1:WIDTH]);

  assign accept = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign ext_a  = is_signed & operand_a[WIDTH-1];
  assign ext_b  = is_signed & operand_b[WIDTH-1];

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    acc_next      = acc_reg;
    mplier_next   = mplier_reg;
    mcand_next    = mcand_reg;
    signed_next   = signed_reg;
    product_next  = product_reg;
    overflow_next = overflow_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        acc_next    = acc_step;
        mplier_next = mplier_reg >> 2;
        count_next  = count_reg + CW'(1);
        if (count_reg == LAST_STEP) begin
          state_next    = ST_DONE;
          count_next    = '0;
          product_next  = final_product;
          overflow_next = final_overflow;
        end
      end
      ST_DONE: begin
        state_next = start ? ST_RUN : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Operands are captured once; later input changes cannot disturb the run.
    if (accept) begin
      count_next  = '0;
      acc_next    = '0;
      mplier_next = {ext_b, ext_b, operand_b, 1'b0};
      mcand_next  = {ext_a, ext_a, operand_a};
      signed_next = is_signed;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      acc_reg      <= '0;
      mplier_reg   <= '0;
      mcand_reg    <= '0;
      signed_reg   <= 1'b0;
      product_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      acc_reg      <= acc_next;
      mplier_reg   <= mplier_next;
      mcand_reg    <= mcand_next;
      signed_reg   <= signed_next;
      product_reg  <= product_next;
      overflow_reg <= overflow_next;
    end
  end

  assign in_ready     = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign busy         = (state_reg == ST_RUN);
  assign result_valid = (state_reg == ST_DONE);
  assign product      = product_reg;
  assign overflow     = overflow_reg;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed bench for booth_seq_multiplier at WIDTH 32, 8 and 4.
module tb_booth_seq_multiplier;

  typedef struct {
    int          w;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    logic        ov;
  } vec_t;

  logic clock = 1'b0;
  logic reset;

  logic        start32, sgn32, rdy32, busy32, vld32, ov32;
  logic [31:0] a32, b32;
  logic [63:0] p32;
  logic        start8, sgn8, rdy8, busy8, vld8, ov8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        start4, sgn4, rdy4, busy4, vld4, ov4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  booth_seq_multiplier #(.WIDTH(32)) u_mul32 (
    .clock(clock), .reset(reset), .start(start32), .is_signed(sgn32),
    .operand_a(a32), .operand_b(b32), .in_ready(rdy32), .busy(busy32),
    .result_valid(vld32), .product(p32), .overflow(ov32)
  );

  booth_seq_multiplier #(.WIDTH(8)) u_mul8 (
    .clock(clock), .reset(reset), .start(start8), .is_signed(sgn8),
    .operand_a(a8), .operand_b(b8), .in_ready(rdy8), .busy(busy8),
    .result_valid(vld8), .product(p8), .overflow(ov8)
  );

  booth_seq_multiplier #(.WIDTH(4)) u_mul4 (
    .clock(clock), .reset(reset), .start(start4), .is_signed(sgn4),
    .operand_a(a4), .operand_b(b4), .in_ready(rdy4), .busy(busy4),
    .result_valid(vld4), .product(p4), .overflow(ov4)
  );

  task automatic drive(input int w, input logic st, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
    case (w)
      4:       begin start4 = st; sgn4 = s; a4 = a[3:0]; b4 = b[3:0]; end
      8:       begin start8 = st; sgn8 = s; a8 = a[7:0]; b8 = b[7:0]; end
      default: begin start32 = st; sgn32 = s; a32 = a; b32 = b; end
    endcase
  endtask

  function automatic logic get_valid(input int w);
    case (w)
      4:       return vld4;
      8:       return vld8;
      default: return vld32;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      4:       return busy4;
      8:       return busy8;
      default: return busy32;
    endcase
  endfunction

  function automatic logic [63:0] get_product(input int w);
    case (w)
      4:       return {56'd0, p4};
      8:       return {48'd0, p8};
      default: return p32;
    endcase
  endfunction

  function automatic logic get_ov(input int w);
    case (w)
      4:       return ov4;
      8:       return ov8;
      default: return ov32;
    endcase
  endfunction

  // Plain arithmetic reference: extend both operands to 64 bits and multiply.
  function automatic logic [63:0] ext_op(input int w, input logic s, input logic [31:0] x);
    logic [63:0] m;
    logic [63:0] v;
    m = (64'd1 << w) - 64'd1;
    v = {32'd0, x} & m;
    if (s && x[w-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [63:0] ref_mul(input int w, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m;
    m = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    return (ext_op(w, s, a) * ext_op(w, s, b)) & m;
  endfunction

  function automatic logic ref_ovf(input int w, input logic s, input logic [63:0] p);
    logic [63:0] top;
    logic [63:0] ones;
    if (!s) return (p >> w) != 64'd0;
    ones = (64'd1 << (w + 1)) - 64'd1;
    top  = (p >> (w - 1)) & ones;
    return (top != 64'd0) && (top != ones);
  endfunction

  // Called with the DUT idle, one cycle after an edge; returns one cycle after DONE.
  task automatic run_op(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] p, output logic ov, output int lat,
                        output logic busy_ok);
    drive(w, 1'b1, s, a, b);
    @(posedge clock); #1;
    drive(w, 1'b0, ~s, ~a, b ^ 32'h5A5A_5A5A);
    lat     = 1;
    busy_ok = 1'b1;
    while (!get_valid(w) && lat < 40) begin
      if (!get_busy(w)) busy_ok = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    p  = get_product(w);
    ov = get_ov(w);
    $display("op w=%0d s=%0d a=%h b=%h product=%h ov=%0d lat=%0d", w, s, a, b, p, ov, lat);
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_vec++; if (rdy32 !== 1'b1) begin n_miss++; $display("FAIL reset_in_ready: got %b want 1", rdy32); end
    n_vec++; if (busy32 !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy32); end
    n_vec++; if (vld32 !== 1'b0) begin n_miss++; $display("FAIL reset_valid: got %b want 0", vld32); end
    n_vec++; if (p32 !== 64'd0) begin n_miss++; $display("FAIL reset_product: got %h want 0", p32); end
    n_vec++; if (ov32 !== 1'b0) begin n_miss++; $display("FAIL reset_overflow: got %b want 0", ov32); end
    n_vec++; if (p8 !== 16'd0 || rdy8 !== 1'b1) begin n_miss++; $display("FAIL reset_w8: got p=%h rdy=%b want 0/1", p8, rdy8); end
    n_vec++; if (p4 !== 8'd0 || rdy4 !== 1'b1) begin n_miss++; $display("FAIL reset_w4: got p=%h rdy=%b want 0/1", p4, rdy4); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_latency;
    logic [63:0] p;
    logic        ov;
    int          lat;
    logic        bok;
    run_op(32, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, p, ov, lat, bok);
    n_vec++; if (lat !== 18) begin n_miss++; $display("FAIL latency: got %0d want 18", lat); end
    n_vec++; if (bok !== 1'b1) begin n_miss++; $display("FAIL busy_during_run: got %b want 1", bok); end
    n_vec++; if (p !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_miss++; $display("FAIL neg3x7_product: got %h want ffffffffffffffeb", p); end
    n_vec++; if (ov !== 1'b0) begin n_miss++; $display("FAIL neg3x7_overflow: got %b want 0", ov); end
    n_vec++; if (vld32 !== 1'b0 || rdy32 !== 1'b1) begin n_miss++; $display("FAIL valid_pulse: got vld=%b rdy=%b want 0/1", vld32, rdy32); end
    n_vec++; if (p32 !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_miss++; $display("FAIL product_hold: got %h want ffffffffffffffeb", p32); end
  endtask

  task automatic test_directed;
    vec_t        tbl[16];
    logic [63:0] p;
    logic        ov;
    int          lat;
    logic        bok;
    tbl = '{
      '{32, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1},
      '{32, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0},
      '{32, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1},
      '{8,  1'b1, 32'h80, 32'hFF, 64'h0080, 1'b1},
      '{8,  1'b0, 32'hFF, 32'hFF, 64'hFE01, 1'b1},
      '{8,  1'b1, 32'h80, 32'h80, 64'h4000, 1'b1},
      '{8,  1'b1, 32'h7F, 32'h7F, 64'h3F01, 1'b1},
      '{8,  1'b0, 32'h0F, 32'h11, 64'h00FF, 1'b0},
      '{8,  1'b1, 32'hFD, 32'h07, 64'hFFEB, 1'b0},
      '{4,  1'b0, 32'hF, 32'hF, 64'hE1, 1'b1},
      '{4,  1'b1, 32'h8, 32'h8, 64'h40, 1'b1},
      '{4,  1'b1, 32'h8, 32'h1, 64'hF8, 1'b0},
      '{4,  1'b1, 32'h7, 32'hF, 64'hF9, 1'b0},
      '{4,  1'b0, 32'h0, 32'hF, 64'h00, 1'b0},
      '{4,  1'b0, 32'h1, 32'hF, 64'h0F, 1'b0},
      '{4,  1'b1, 32'h7, 32'h7, 64'h31, 1'b1}
    };
    for (int i = 0; i < 16; i++) begin
      run_op(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].b, p, ov, lat, bok);
      n_vec++; if (p !== tbl[i].p) begin n_miss++; $display("FAIL directed_product[%0d]: got %h want %h", i, p, tbl[i].p); end
      n_vec++; if (ov !== tbl[i].ov) begin n_miss++; $display("FAIL directed_overflow[%0d]: got %b want %b", i, ov, tbl[i].ov); end
      n_vec++; if (lat !== tbl[i].w / 2 + 2) begin n_miss++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, tbl[i].w / 2 + 2); end
    end
  endtask

  task automatic test_corners;
    int          widths[3];
    logic [31:0] corner[5];
    logic [63:0] p;
    logic [63:0] exp_p;
    logic        ov;
    int          lat;
    logic        bok;
    int          w;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    widths = '{4, 8, 32};
    for (int wi = 0; wi < 3; wi++) begin
      w = widths[wi];
      corner[0] = 32'd0;
      corner[1] = 32'd1;
      corner[2] = 32'(({32'd0, 32'hFFFF_FFFF}) >> (32 - w));
      corner[3] = 32'(64'd1 << (w - 1));
      corner[4] = corner[3] - 32'd1;
      for (int si = 0; si < 2; si++) begin
        s = si[0];
        for (int ai = 0; ai < 5; ai++) begin
          for (int bi = 0; bi < 5; bi++) begin
            run_op(w, s, corner[ai], corner[bi], p, ov, lat, bok);
            exp_p = ref_mul(w, s, corner[ai], corner[bi]);
            n_vec++; if (p !== exp_p) begin n_miss++; $display("FAIL corner_product w=%0d s=%0d: got %h want %h", w, s, p, exp_p); end
            n_vec++; if (ov !== ref_ovf(w, s, exp_p)) begin n_miss++; $display("FAIL corner_overflow w=%0d s=%0d: got %b want %b", w, s, ov, ref_ovf(w, s, exp_p)); end
          end
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      s = i[0];
      run_op(32, s, a, b, p, ov, lat, bok);
      exp_p = ref_mul(32, s, a, b);
      n_vec++; if (p !== exp_p) begin n_miss++; $display("FAIL random_product s=%0d: got %h want %h", s, p, exp_p); end
      n_vec++; if (ov !== ref_ovf(32, s, exp_p)) begin n_miss++; $display("FAIL random_overflow s=%0d: got %b want %b", s, ov, ref_ovf(32, s, exp_p)); end
    end
  endtask

  task automatic test_back_to_back;
    vec_t tbl[5];
    int   q[$];
    int   last_valid;
    int   n_results;
    int   idx;
    int   e;
    int   k;
    tbl = '{
      '{32, 1'b0, 32'h0000_0010, 32'h0000_0020, 64'h0000_0000_0000_0200, 1'b0},
      '{32, 1'b1, 32'hFFFF_FFFE, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0},
      '{32, 1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1},
      '{32, 1'b1, 32'h7FFF_FFFF, 32'h0000_0002, 64'h0000_0000_FFFF_FFFE, 1'b1},
      '{32, 1'b1, 32'h0000_1234, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_EDCC, 1'b0}
    };
    last_valid = -1;
    n_results  = 0;
    for (k = 0; k < 100; k++) begin
      if (vld32) begin
        if (q.size() == 0) begin
          n_vec++; n_miss++; $display("FAIL b2b_unexpected_valid: got valid at step %0d want none", k);
        end else begin
          e = q.pop_front();
          n_vec++; if (p32 !== tbl[e].p) begin n_miss++; $display("FAIL b2b_product[%0d]: got %h want %h", e, p32, tbl[e].p); end
          n_vec++; if (ov32 !== tbl[e].ov) begin n_miss++; $display("FAIL b2b_overflow[%0d]: got %b want %b", e, ov32, tbl[e].ov); end
        end
        if (last_valid >= 0) begin
          n_vec++; if (k - last_valid !== 18) begin n_miss++; $display("FAIL b2b_spacing: got %0d want 18", k - last_valid); end
        end
        last_valid = k;
        n_results++;
      end
      if (k >= 60 && q.size() == 0) break;
      idx = k % 5;
      if (k < 60) begin
        drive(32, 1'b1, tbl[idx].s, tbl[idx].a, tbl[idx].b);
        if (rdy32) q.push_back(idx);
      end else begin
        drive(32, 1'b0, 1'b0, 32'd0, 32'd0);
      end
      @(posedge clock); #1;
    end
    n_vec++; if (n_results !== 4) begin n_miss++; $display("FAIL b2b_result_count: got %0d want 4", n_results); end
    drive(32, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic test_reset_abort;
    logic [63:0] p;
    logic        ov;
    int          lat;
    logic        bok;
    logic        seen;
    run_op(32, 1'b0, 32'h0000_1234, 32'h0000_0010, p, ov, lat, bok);
    n_vec++; if (p !== 64'h0000_0000_0001_2340) begin n_miss++; $display("FAIL abort_pre_product: got %h want 12340", p); end
    drive(32, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0005);
    @(posedge clock); #1;
    drive(32, 1'b0, 1'b0, 32'h0000_0003, 32'h0000_0005);
    repeat (4) begin @(posedge clock); #1; end
    n_vec++; if (busy32 !== 1'b1) begin n_miss++; $display("FAIL abort_busy_before: got %b want 1", busy32); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_vec++; if (rdy32 !== 1'b1) begin n_miss++; $display("FAIL abort_in_ready: got %b want 1", rdy32); end
    n_vec++; if (busy32 !== 1'b0) begin n_miss++; $display("FAIL abort_busy: got %b want 0", busy32); end
    n_vec++; if (p32 !== 64'd0) begin n_miss++; $display("FAIL abort_product: got %h want 0", p32); end
    n_vec++; if (ov32 !== 1'b0) begin n_miss++; $display("FAIL abort_overflow: got %b want 0", ov32); end
    seen = vld32;
    repeat (25) begin
      @(posedge clock); #1;
      if (vld32) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_miss++; $display("FAIL abort_no_valid: got %b want 0", seen); end
    run_op(32, 1'b1, 32'hFFFF_FFF0, 32'h0000_0010, p, ov, lat, bok);
    n_vec++; if (p !== 64'hFFFF_FFFF_FFFF_FF00) begin n_miss++; $display("FAIL abort_post_product: got %h want ffffffffffffff00", p); end
    n_vec++; if (ov !== 1'b0) begin n_miss++; $display("FAIL abort_post_overflow: got %b want 0", ov); end
    n_vec++; if (lat !== 18) begin n_miss++; $display("FAIL abort_post_latency: got %0d want 18", lat); end
  endtask

  initial begin
    reset = 1'b1;
    drive(32, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(4, 1'b0, 1'b0, 32'd0, 32'd0);
    test_reset();
    test_latency();
    test_directed();
    test_corners();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
